// File: rtl/coord_uart_tx.sv
// Coordinate FIFO plus 8N1 UART framer for the IPU blob-centroid stream.
// Optional build macro COORD_TX_CHECKSUM_EN appends an XOR checksum byte to each packet.
module coord_uart_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic [10:0]                   iX,
  input  logic [10:0]                   iY,
  input  logic                          iDVAL,
  output logic                          oTX,
  output logic                          oBusy,
  output logic                          oOverflow,
  output logic [$clog2(FIFO_DEPTH):0]   oCount
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TMR_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
`ifdef COORD_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;
`else
  localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [21:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             ovf_r;
  logic             busy_r;

  state_t           state_r;
  logic [TMR_W-1:0] timer_r;
  logic [2:0]       bit_idx_r;
  logic [2:0]       byte_idx_r;
  logic [7:0]       shift_r;
  logic [21:0]      latch_r;
  logic             tx_r;

  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             expire_s;
  logic             pkt_done_s;
  logic [CNT_W-1:0] count_nxt_s;

`ifdef COORD_TX_CHECKSUM_EN
  function automatic logic [7:0] checksum(input logic [21:0] coord);
    checksum = {5'b00000, coord[10:8]} ^ coord[7:0] ^ {5'b00000, coord[21:19]} ^ coord[18:11];
  endfunction
`endif

  // coord packs {Y, X}; byte 0 is the sync marker
  function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic [21:0] coord);
    case (idx)
      3'd0:    pkt_byte = 8'hA5;
      3'd1:    pkt_byte = {5'b00000, coord[10:8]};
      3'd2:    pkt_byte = coord[7:0];
      3'd3:    pkt_byte = {5'b00000, coord[21:19]};
      3'd4:    pkt_byte = coord[18:11];
`ifdef COORD_TX_CHECKSUM_EN
      3'd5:    pkt_byte = checksum(coord);
`endif
      default: pkt_byte = 8'hFF;
    endcase
  endfunction

  // FIFO handshake decode and next occupancy
  always_comb begin
    full_s     = (count_r == CNT_FULL);
    pop_s      = (state_r == IDLE) && (count_r != '0);
    push_s     = iDVAL && (!full_s || pop_s);
    drop_s     = iDVAL && full_s && !pop_s;
    expire_s   = (timer_r == '0);
    pkt_done_s = (state_r == STOP) && expire_s && (byte_idx_r == LAST_BYTE);
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, no reset needed since occupancy gates every read
  always_ff @(posedge iCLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {iY, iX};
    end
  end

  // FIFO pointers, occupancy, overflow pulse and busy flag
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      ovf_r   <= drop_s;
      // busy is built from next-cycle state so it matches (state != IDLE) || (count != 0) exactly
      busy_r  <= (count_nxt_s != '0) || pop_s || ((state_r != IDLE) && !pkt_done_s);
    end
  end

  // Packet framer FSM; the line output lags the state by one cycle
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_r    <= IDLE;
      timer_r    <= '0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 3'd0;
      shift_r    <= 8'hFF;
      latch_r    <= 22'd0;
      tx_r       <= 1'b1;
    end else begin
      case (state_r)
        START:   tx_r <= 1'b0;
        DATA:    tx_r <= shift_r[0];
        default: tx_r <= 1'b1;
      endcase

      case (state_r)
        IDLE: begin
          if (pop_s) begin
            latch_r    <= mem_r[rd_ptr_r];
            byte_idx_r <= 3'd0;
            timer_r    <= TMR_LOAD;
            state_r    <= START;
          end
        end
        START: begin
          if (expire_s) begin
            shift_r   <= pkt_byte(byte_idx_r, latch_r);
            bit_idx_r <= 3'd0;
            timer_r   <= TMR_LOAD;
            state_r   <= DATA;
          end else begin
            timer_r <= timer_r - TMR_W'(1'b1);
          end
        end
        DATA: begin
          if (expire_s) begin
            shift_r <= {1'b1, shift_r[7:1]};
            timer_r <= TMR_LOAD;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            timer_r <= timer_r - TMR_W'(1'b1);
          end
        end
        STOP: begin
          if (expire_s) begin
            if (byte_idx_r == LAST_BYTE) begin
              state_r <= IDLE;
            end else begin
              byte_idx_r <= byte_idx_r + 3'd1;
              timer_r    <= TMR_LOAD;
              state_r    <= START;
            end
          end else begin
            timer_r <= timer_r - TMR_W'(1'b1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign oTX       = tx_r;
  assign oBusy     = busy_r;
  assign oOverflow = ovf_r;
  assign oCount    = count_r;

endmodule
